// File: rtl/screen_scanout_if.sv
// Synchronous read port from the VGA scanout into the 8K-word Hack screen memory.
interface screen_scanout_if;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 16;

    logic [AW-1:0] scr_addr;
    logic          scr_rd;
    logic [DW-1:0] scr_data;

    modport master (output scr_addr, output scr_rd, input scr_data);
    modport slave  (input scr_addr, input scr_rd, output scr_data);
endinterface

// File: rtl/screen_scanout.sv
// 640x480@60 VGA scanout of the 512x256 Hack screen, centred with a black border.
// Sync, enable and pixel all leave the block two cycles after the raster counters.
module screen_scanout #(
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned X0     = 64,
    parameter int unsigned Y0     = 112
) (
    input  logic             clk,
    input  logic             reset,
    screen_scanout_if.master scr,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             vga_de,
    output logic             vga_px,
    output logic             frame_start
);
    localparam int unsigned HW      = 10;
    localparam int unsigned VW      = 10;
    localparam int unsigned AW      = 13;
    localparam int unsigned DW      = 16;
    localparam int unsigned IMG_W   = 512;
    localparam int unsigned IMG_H   = 256;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_C = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG   = HW'(X0);
    localparam logic [HW-1:0] X_END   = HW'(X0 + IMG_W);
    // Read for word k is issued one cycle early, so its request is decided two cycles early.
    localparam logic [HW-1:0] RD_BEG  = HW'(X0 - 2);
    localparam logic [HW-1:0] RD_END  = HW'(X0 + IMG_W - 18);
    localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_C = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG   = VW'(Y0);
    localparam logic [VW-1:0] Y_END   = VW'(Y0 + IMG_H);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hs_q, vs_q, de_q, win_q, fs_q, rd_d;
    logic [DW-1:0] shreg;

    logic          vis_c, hs_c, vs_c, line_c, win_c, rd_c, fs_c;
    logic [8:0]    hx_c;
    logic [7:0]    yi_c;
    logic [AW-1:0] addr_c;

    // Raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_MAX) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_MAX) ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Timing decode and fetch scheduling from the current counter position
    always_comb begin
        vis_c  = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
        hs_c   = !((hcnt >= HS_BEG) && (hcnt < HS_END));
        vs_c   = !((vcnt >= VS_BEG) && (vcnt < VS_END));
        line_c = (vcnt >= Y_BEG) && (vcnt < Y_END) && (vcnt < V_VIS_C);
        win_c  = line_c && vis_c && (hcnt >= X_BEG) && (hcnt < X_END);
        fs_c   = (hcnt == '0) && (vcnt == '0);
        hx_c   = 9'(hcnt - RD_BEG);
        yi_c   = 8'(vcnt - Y_BEG);
        rd_c   = line_c && (hcnt >= RD_BEG) && (hcnt <= RD_END) && (hx_c[3:0] == 4'd0);
        addr_c = {yi_c, hx_c[8:4]};
    end

    // Fetch, shift register and two-stage output pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            scr.scr_rd   <= 1'b0;
            scr.scr_addr <= '0;
            rd_d         <= 1'b0;
            shreg        <= '0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            de_q         <= 1'b0;
            win_q        <= 1'b0;
            fs_q         <= 1'b0;
            vga_hsync    <= 1'b1;
            vga_vsync    <= 1'b1;
            vga_de       <= 1'b0;
            vga_px       <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            scr.scr_rd <= rd_c;
            if (rd_c) begin
                scr.scr_addr <= addr_c;
            end
            rd_d  <= scr.scr_rd;
            shreg <= rd_d ? scr.scr_data : {1'b0, shreg[DW-1:1]};
            hs_q  <= hs_c;
            vs_q  <= vs_c;
            de_q  <= vis_c;
            win_q <= win_c;
            fs_q  <= fs_c;
            vga_hsync   <= hs_q;
            vga_vsync   <= vs_q;
            vga_de      <= de_q;
            // Hack stores 1 as black; bit 0 is the leftmost pixel of the word
            vga_px      <= win_q & ~shreg[0];
            frame_start <= fs_q;
        end
    end
endmodule

// File: tb/tb_screen_scanout.sv
// Scoreboard bench for screen_scanout on a vertically shortened raster.
`timescale 1ns/1ps
module tb_screen_scanout;
    localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_VIS = 10, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int X0 = 64, Y0 = 2;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic px;
        logic fs;
    } pins_t;
    localparam pins_t RST_PINS = pins_t'(5'b11000);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vga_hsync, vga_vsync, vga_de, vga_px, frame_start;
    logic [15:0] mem [8192];

    screen_scanout_if bus ();

    screen_scanout #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .X0(X0), .Y0(Y0)
    ) dut (
        .clk(clk), .reset(reset), .scr(bus),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
        .vga_px(vga_px), .frame_start(frame_start)
    );

    always #20 clk = ~clk;

    // Synchronous screen memory; data bus carries junk when not read
    always @(posedge clk) bus.scr_data <= bus.scr_rd ? mem[bus.scr_addr] : 16'($urandom);

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic pins_t exp_pins(int h, int v);
        pins_t p;
        int xi, yi;
        logic [15:0] w;
        p.hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        p.vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        p.de = (h < H_VIS) && (v < V_VIS);
        p.fs = (h == 0) && (v == 0);
        p.px = 1'b0;
        xi = h - X0;
        yi = v - Y0;
        if (p.de && xi >= 0 && xi < 512 && yi >= 0 && yi < 256) begin
            w = mem[yi * 32 + xi / 16];
            p.px = ~w[xi % 16];
        end
        return p;
    endfunction

    function automatic bit rd_at(int h, int v);
        int xi, yi;
        xi = h + 1 - X0;
        yi = v - Y0;
        return (v < V_VIS) && yi >= 0 && yi < 256 && xi >= 0 && xi < 512 && (xi % 16 == 0);
    endfunction

    function automatic int addr_at(int h, int v);
        return (v - Y0) * 32 + (h + 1 - X0) / 16;
    endfunction

    // Producer: reference raster position; pushes expected pins and read addresses
    int mh = 0, mv = 0, mfr = 0, epoch = 0;
    bit started = 0, prev_rst = 0;
    pins_t pq[$];
    int aq[$];

    initial forever begin
        @(posedge clk);
        if (reset) begin
            if (!prev_rst) epoch++;
            mh = 0; mv = 0; mfr = 0;
            pq.delete();
            pq.push_back(RST_PINS);
            pq.push_back(RST_PINS);
            aq.delete();
            started = 1;
        end else begin
            pq.push_back(exp_pins(mh, mv));
            if (mh == H_TOT - 1) begin
                mh = 0;
                if (mv == V_TOT - 1) begin mv = 0; mfr++; end
                else mv++;
            end else begin
                mh++;
            end
            if (rd_at(mh, mv)) aq.push_back(addr_at(mh, mv));
        end
        prev_rst = reset;
    end

    // Hand-computed pixel and read points (pixel for hcnt=h seen when raster is at h+2)
    localparam int NPP = 22;
    int pp_v [NPP] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 4, 4, 4, 9, 9, 9, 9, 9, 10};
    int pp_h [NPP] = '{64, 300, 63, 64, 65, 300, 574, 575, 576, 67, 68, 71, 72, 559, 560, 575,
                       560, 562, 563, 572, 575, 300};
    int pp_x [NPP] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0};
    localparam int NRP = 5;
    int rp_v [NRP] = '{2, 2, 2, 3, 9};
    int rp_h [NRP] = '{63, 79, 559, 63, 559};
    int rp_a [NRP] = '{0, 1, 31, 32, 255};

    // Monitor: pops expectations as the DUT presents pins and reads
    pins_t act_p, exp_p;
    int a, period, de_cnt, vs_cnt, rd_cnt, sig, sig_clean, fdone, last_epoch;
    bit seg_valid = 0, sig_done = 0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            act_p = {vga_hsync, vga_vsync, vga_de, vga_px, frame_start};
            if (pq.size() == 0) chk(1'b0, "pin_queue_empty", 0, 1);
            else begin
                exp_p = pq.pop_front();
                chk(act_p === exp_p, "pins", act_p, exp_p);
            end
            chk(bus.scr_rd === rd_at(mh, mv), "rd_timing", bus.scr_rd, rd_at(mh, mv));
            if (bus.scr_rd === 1'b1) begin
                if (aq.size() == 0) chk(1'b0, "rd_unexpected", bus.scr_addr, 0);
                else begin
                    a = aq.pop_front();
                    chk(bus.scr_addr === 13'(a), "rd_addr", bus.scr_addr, a);
                end
            end
            for (int i = 0; i < NPP; i++)
                if (mv == pp_v[i] && mh == pp_h[i] + 2)
                    chk(vga_px === 1'(pp_x[i]), $sformatf("px_v%0d_h%0d", pp_v[i], pp_h[i]),
                        vga_px, pp_x[i]);
            for (int i = 0; i < NRP; i++)
                if (mv == rp_v[i] && mh == rp_h[i])
                    chk(bus.scr_rd === 1'b1 && bus.scr_addr === 13'(rp_a[i]),
                        $sformatf("rd_v%0d_h%0d", rp_v[i], rp_h[i]), bus.scr_addr, rp_a[i]);
            if (epoch != last_epoch) begin
                seg_valid = 0; fdone = 0; last_epoch = epoch;
            end
            if (frame_start === 1'b1) begin
                chk(vga_de === 1'b1, "fs_with_de", vga_de, 1);
                if (seg_valid) begin
                    chk(period == FRAME, "frame_period", period, FRAME);
                    chk(de_cnt == H_VIS * V_VIS, "de_count", de_cnt, H_VIS * V_VIS);
                    chk(vs_cnt == V_SYNC * H_TOT, "vsync_low", vs_cnt, V_SYNC * H_TOT);
                    chk(rd_cnt == 256, "reads_per_frame", rd_cnt, 256);
                    fdone++;
                    if (fdone == 1) begin
                        if (epoch == 1) sig_clean = sig;
                        else if (epoch == 2) begin
                            chk(sig == sig_clean, "frame_after_reset", sig, sig_clean);
                            sig_done = 1;
                        end
                    end
                end
                seg_valid = 1; period = 0; de_cnt = 0; vs_cnt = 0; rd_cnt = 0; sig = 0;
            end
            period++;
            de_cnt += int'(vga_de === 1'b1);
            vs_cnt += int'(vga_vsync === 1'b0);
            rd_cnt += int'(bus.scr_rd === 1'b1);
            sig = sig * 33 + int'(act_p);
        end
    end

    // Stimulus
    int n, n_low, n_high;
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0001; mem[31] = 16'h8000; mem[32] = 16'h00F0;
        mem[95] = 16'hFFFF; mem[255] = 16'h1234;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({vga_hsync, vga_vsync, vga_de, vga_px, frame_start, bus.scr_rd} === 6'b110000,
            "reset_pins", {vga_hsync, vga_vsync, vga_de, vga_px, frame_start, bus.scr_rd}, 6'b110000);
        chk(bus.scr_addr === 13'd0, "reset_addr", bus.scr_addr, 0);
        reset = 1'b0;

        n = 0;
        while (vga_hsync === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        chk(n == H_VIS + H_FP + 2, "first_hsync_fall", n, H_VIS + H_FP + 2);
        n_low = 0;
        while (vga_hsync === 1'b0 && n_low < 2000) begin @(negedge clk); n_low++; end
        chk(n_low == H_SYNC, "hsync_width", n_low, H_SYNC);
        n_high = 0;
        while (vga_hsync === 1'b1 && n_high < 2000) begin @(negedge clk); n_high++; end
        chk(n_low + n_high == H_TOT, "line_period", n_low + n_high, H_TOT);

        n = 0;
        while (!(mfr == 2 && mv == 5 && mh == 303) && n < 40000) begin @(negedge clk); n++; end
        chk(n < 40000, "reach_mid_fetch", n, 40000);
        reset = 1'b1;
        @(negedge clk);
        chk({vga_hsync, vga_vsync, vga_de, vga_px, frame_start, bus.scr_rd} === 6'b110000,
            "midreset_pins", {vga_hsync, vga_vsync, vga_de, vga_px, frame_start, bus.scr_rd}, 6'b110000);
        chk(bus.scr_addr === 13'd0, "midreset_addr", bus.scr_addr, 0);
        reset = 1'b0;

        n = 0;
        while (!sig_done && n < 30000) begin @(negedge clk); n++; end
        chk(sig_done, "frame_after_reset_seen", sig_done, 1);
        repeat (4) @(posedge clk);
        chk(aq.size() == 0, "reads_drained", aq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
